// File: rtl/vc_plane_arbiter_mux.sv
// Round-robin VC-plane arbiter with packet hold, bounded-hold preemption and a
// registered mux forwarding the granted plane's switch-control slice.
module vc_plane_arbiter_mux #(
    parameter int VC            = 4,
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int REQUEST_WIDTH = 2,
    parameter int MAX_HOLD      = 16,
    parameter int SEL_W         = (VC > 1) ? $clog2(VC) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [VC-1:0]                     vcRequest,
    input  logic [VC-1:0]                     vcRelease,
    input  logic [VC*OUTPUTS*REQUEST_WIDTH-1:0] routeSelectVC,
    input  logic [VC*OUTPUTS-1:0]             outputBusyVC,
    input  logic [VC*INPUTS-1:0]              PortReservedVC,
    input  logic [VC*INPUTS-1:0]              routeReserveStatusVC,
    output logic [SEL_W-1:0]                  VCPlaneSelector,
    output logic                              VCPlaneValid,
    output logic [VC-1:0]                     vcGrant,
    output logic [OUTPUTS*REQUEST_WIDTH-1:0]  routeSelect,
    output logic [OUTPUTS-1:0]                outputBusy,
    output logic [INPUTS-1:0]                 PortReserved,
    output logic [INPUTS-1:0]                 routeReserveStatus
);

    localparam int RS_W  = OUTPUTS * REQUEST_WIDTH;
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [VC-1:0][RS_W-1:0]    rsArr;
    logic [VC-1:0][OUTPUTS-1:0] obArr;
    logic [VC-1:0][INPUTS-1:0]  prArr;
    logic [VC-1:0][INPUTS-1:0]  rrsArr;

    assign rsArr  = routeSelectVC;
    assign obArr  = outputBusyVC;
    assign prArr  = PortReservedVC;
    assign rrsArr = routeReserveStatusVC;

    logic [0:0]       stateQ, stateN;
    logic [SEL_W-1:0] selQ, selN, ptrQ, ptrN;
    logic [CNT_W-1:0] cntQ, cntN;
    logic [VC-1:0]    selHot, selHotN, mask;
    logic [SEL_W:0]   found;
    logic             relDrop, preempt;

    // First set bit of mask at or after 'from' (circular); MSB of result flags a hit.
    function automatic logic [SEL_W:0] search(input int from, input logic [VC-1:0] m);
        logic [SEL_W:0] r;
        int idx;
        r = '0;
        for (int i = VC - 1; i >= 0; i--) begin
            idx = (from + i) % VC;
            if (m[idx]) r = {1'b1, idx[SEL_W-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        stateN  = stateQ;
        selN    = selQ;
        ptrN    = ptrQ;
        cntN    = cntQ;
        found   = '0;
        relDrop = 1'b0;
        preempt = 1'b0;
        mask    = vcRequest;
        selHot  = '0;
        selHot[selQ] = 1'b1;

        if (stateQ == IDLE) begin
            found = search(int'(ptrQ), vcRequest);
        end else begin
            relDrop = vcRelease[selQ] | ~vcRequest[selQ];
            preempt = (cntQ == CNT_MAX) && (|(vcRequest & ~selHot));
            if (relDrop || preempt) begin
                // A preempted plane still requests and stays eligible behind the others.
                mask  = relDrop ? (vcRequest & ~selHot) : vcRequest;
                found = search(int'(selQ) + 1, mask);
                if (!found[SEL_W]) begin
                    stateN = IDLE;
                    selN   = '0;
                end
            end else if (cntQ != CNT_MAX) begin
                cntN = cntQ + 1'b1;
            end
        end

        if (found[SEL_W]) begin
            stateN = HOLD;
            selN   = found[SEL_W-1:0];
            ptrN   = SEL_W'((int'(found[SEL_W-1:0]) + 1) % VC);
            cntN   = '0;
        end

        selHotN = '0;
        selHotN[selN] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ             <= IDLE;
            selQ               <= '0;
            ptrQ               <= '0;
            cntQ               <= '0;
            vcGrant            <= '0;
            routeSelect        <= '0;
            outputBusy         <= '0;
            PortReserved       <= '0;
            routeReserveStatus <= '0;
        end else begin
            stateQ <= stateN;
            selQ   <= selN;
            ptrQ   <= ptrN;
            cntQ   <= cntN;
            if (stateN == HOLD) begin
                vcGrant            <= selHotN;
                routeSelect        <= rsArr[selN];
                outputBusy         <= obArr[selN];
                PortReserved       <= prArr[selN];
                routeReserveStatus <= rrsArr[selN];
            end else begin
                vcGrant            <= '0;
                routeSelect        <= '0;
                outputBusy         <= '0;
                PortReserved       <= '0;
                routeReserveStatus <= '0;
            end
        end
    end

    assign VCPlaneSelector = selQ;
    assign VCPlaneValid    = stateQ;

endmodule

// File: doc/vc_plane_arbiter_mux.md
# vc_plane_arbiter_mux

Round-robin VC-plane arbiter with a registered switch-control multiplexer. Each cycle it selects one active virtual-channel plane out of `VC` and holds it for a whole packet. It then forwards that plane's switch-control slice (route select, output busy, port reserved, route-reserve status) to the Switch and the HFB through one register stage. It replaces the externally driven plane selector with internal fair arbitration, packet-hold, bubble-free hand-over and bounded-hold preemption.

## Interface
- `VC`, 4, number of VC planes (≥1)
- `INPUTS`, 4, router input ports
- `OUTPUTS`, 4, router output ports
- `REQUEST_WIDTH`, 2, route-select bits per output
- `MAX_HOLD`, 16, cycles one plane may hold the grant while another plane requests (≥2)
- `SEL_W`, derived: `$clog2(VC)`, or 1 when `VC`=1
- `clk`  in  1  clock, all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `vcRequest`  in  VC  plane v has a flit pending
- `vcRelease`  in  VC  plane v's tail flit is traversing the switch this cycle
- `routeSelectVC`  in  VC*OUTPUTS*REQUEST_WIDTH  per-plane route selects, plane v at `[v*OUTPUTS*REQUEST_WIDTH +: OUTPUTS*REQUEST_WIDTH]`
- `outputBusyVC`  in  VC*OUTPUTS  per-plane output busy
- `PortReservedVC`  in  VC*INPUTS  per-plane port reserved
- `routeReserveStatusVC`  in  VC*INPUTS  per-plane reserve status
- `VCPlaneSelector`  out  SEL_W  registered binary index of the granted plane
- `VCPlaneValid`  out  1  registered; a plane is granted
- `vcGrant`  out  VC  registered one-hot grant, all zero when invalid
- `routeSelect`  out  OUTPUTS*REQUEST_WIDTH  registered slice of the granted plane
- `outputBusy`  out  OUTPUTS  registered
- `PortReserved`  out  INPUTS  registered
- `routeReserveStatus`  out  INPUTS  registered

## Operation
- **Reset:** all outputs 0, state IDLE, round-robin pointer `ptr`=0, `holdCnt`=0.
- **Search:** "next requester from p" is the first v in order p, p+1, … mod VC with `vcRequest[v]`=1.
- **IDLE:**
  - If no request, stay in IDLE.
  - Otherwise grant s = next requester from `ptr`, go to HOLD.
  - Set `ptr`=(s+1) mod VC and `holdCnt`=0.
- **HOLD with plane s:**
  - `holdCnt` increments each cycle and saturates at MAX_HOLD-1.
  - End of hold occurs when any of these is true:
    - `vcRelease[s]`=1;
    - `vcRequest[s]`=0;
    - `holdCnt`=MAX_HOLD-1 and another plane requests (preemption).
  - At end of hold, search from (s+1) mod VC, excluding s only on release or request drop.
  - If a plane is found, grant it directly without an IDLE bubble, update `ptr`, and clear `holdCnt`. Otherwise go to IDLE.
  - On preemption, s keeps its request, so it is re-eligible later in round-robin order.
- **No competitor:** while no other plane requests, s keeps the grant indefinitely and `holdCnt` stays saturated.
- **Output register:** at every edge the data outputs load the slice of the plane being granted for the next cycle (next-state select), sampled at that edge. When the next state is IDLE they load 0. `vcGrant`=1<<`VCPlaneSelector` whenever `VCPlaneValid`=1.
- **VC=1:** `VCPlaneSelector`=0. Preemption never fires.

## Timing
- Request-to-grant latency: request high before edge k gives `VCPlaneValid`/`vcGrant` after edge k.
- Data outputs after edge k equal the slice of `*VC` inputs sampled at edge k, aligned with the grant. Latency is 1 cycle from any `*VC` input change.
- Hand-over: `vcRelease[s]` sampled at edge k gives the new grant after edge k, with 0 idle cycles.
- Release with no other requester: outputs 0 and `VCPlaneValid`=0 after edge k.
- `vcRelease` on a non-granted plane is ignored.
- Simultaneous release of s and a new request from s: s is excluded from this search. If s is the only requester, it is re-granted after one IDLE cycle.
- Asynchronous reset mid-packet: all outputs clear immediately. The first post-reset grant searches from plane 0.

## Test plan
- **Reset:** hold `rst`=0 mid-grant with VC=4 -> all outputs 0 immediately. After release, with `vcRequest`=4'b0100, expect `VCPlaneSelector`=2, `vcGrant`=4'b0100 after the first edge.
- **Round robin:** `vcRequest`=4'b1111, pulse `vcRelease` of the granted plane every 3rd cycle -> grant order 0,1,2,3,0 with no idle cycle between grants.
- **Data path:** grant plane 1; set `routeSelectVC` plane-1 slice=8'hA5 and plane-0 slice=8'h3C -> `routeSelect`=8'hA5 one cycle later. Change the plane-1 slice to 8'h5A -> `routeSelect` updates after exactly 1 edge.
- **Preemption:** MAX_HOLD=4, plane 0 requests continuously without release, plane 2 requests from cycle 1 -> plane 0 holds 4 cycles, then plane 2 is granted. Plane 0 is re-granted after plane 2 releases.
- **Request drop:** plane 3 granted, `vcRequest[3]` falls with no other request -> `VCPlaneValid`=0 and all data outputs 0 next cycle.
- **Same-cycle release and re-request:** only plane 1 requests and releases while keeping `vcRequest[1]`=1 -> one IDLE cycle, then plane 1 is re-granted.
